// File: rtl/vip_out_reader.sv
// vip_out_reader: drains result words from the accelerator output FIFO into
// result memory, one WIDTH*HEIGHT frame per start pulse.
// A 2-entry skid buffer plus a one-deep in-flight flag absorbs the 1-cycle
// FIFO read latency, so a stalled memory port never loses a word.
// The end-of-frame tag (bit DWIDTH) is checked against the word index, but
// frame length always comes from the word count, never from the tag.
// Optional build macro VIP_OUT_RELU_EN: when defined, a negative payload is
// written as zero.  This is applied as the word enters the skid buffer.
module vip_out_reader #(
   parameter int DWIDTH    = 32,
   parameter int WIDTH     = 56,
   parameter int HEIGHT    = 56,
   parameter int AWIDTH    = 16,
   parameter int ADDR_STEP = 1
) (
   input  logic                                 clock,
   input  logic                                 resetn,
   input  logic                                 start,
   input  logic [AWIDTH-1:0]                    base_addr,
   input  logic [DWIDTH:0]                      fifo_out_data,
   output logic                                 fifo_out_rdreq,
   input  logic                                 fifo_out_empty,
   output logic [AWIDTH-1:0]                    mem_addr,
   output logic [DWIDTH-1:0]                    mem_wdata,
   output logic                                 mem_we,
   input  logic                                 mem_ready,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err_last,
   output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    pix_count
);

   localparam int FRAME = WIDTH * HEIGHT;
   localparam int CW    = $clog2(FRAME + 1);
   localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME - 1);
   localparam logic [CW-1:0] FRAME_LEN = CW'(FRAME);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic [CW-1:0]       pix_q, pix_d;
   logic [CW-1:0]       popped_q, popped_d;
   logic [CW-1:0]       capt_q, capt_d;
   logic                infl_q, infl_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [DWIDTH-1:0]   buf0_q, buf0_d;
   logic [DWIDTH-1:0]   buf1_q, buf1_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic                accept_s;
   logic                capture_s;
   logic                rdreq_s;
   logic [2:0]          occ_s;
   logic [DWIDTH-1:0]   cap_word_s;

   // Payload shaping at capture: optional clamp of negative values to zero.
   function automatic logic [DWIDTH-1:0] shape_payload(input logic [DWIDTH-1:0] v);
`ifdef VIP_OUT_RELU_EN
      if (v[DWIDTH-1]) begin
         return {DWIDTH{1'b0}};
      end else begin
         return v;
      end
`else
      return v;
`endif
   endfunction

   assign fifo_out_rdreq = rdreq_s;
   assign mem_we         = (cnt_q != 2'd0);
   assign mem_wdata      = buf0_q;
   assign mem_addr       = addr_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err_last       = err_q;
   assign pix_count      = pix_q;

   // Next-state logic: FSM, FIFO pop request, skid buffer, tag check, write side.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      pix_d      = pix_q;
      popped_d   = popped_q;
      capt_d     = capt_q;
      cnt_d      = cnt_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      err_d      = err_q;
      done_d     = 1'b0;
      busy_d     = busy_q;
      accept_s   = 1'b0;
      capture_s  = 1'b0;
      rdreq_s    = 1'b0;
      occ_s      = {1'b0, cnt_q} + {2'b00, infl_q};
      cap_word_s = shape_payload(fifo_out_data[DWIDTH-1:0]);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               busy_d   = 1'b1;
               addr_d   = base_addr;
               pix_d    = {CW{1'b0}};
               popped_d = {CW{1'b0}};
               capt_d   = {CW{1'b0}};
               cnt_d    = 2'd0;
               err_d    = 1'b0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            accept_s  = (cnt_q != 2'd0) && mem_ready;
            capture_s = infl_q;
            // A word accepted this cycle frees its slot in time for the next capture.
            if (!fifo_out_empty && (cnt_q != 2'd2) && (popped_q < FRAME_LEN) &&
                ((occ_s < 3'd2) || (accept_s && (occ_s < 3'd3)))) begin
               rdreq_s  = 1'b1;
               popped_d = popped_q + CW'(1);
            end else begin
               rdreq_s  = 1'b0;
            end

            case ({accept_s, capture_s})
               2'b11: begin
                  if (cnt_q == 2'd1) begin
                     buf0_d = cap_word_s;
                  end else begin
                     buf0_d = buf1_q;
                     buf1_d = cap_word_s;
                  end
               end
               2'b10: begin
                  buf0_d = buf1_q;
                  cnt_d  = cnt_q - 2'd1;
               end
               2'b01: begin
                  if (cnt_q == 2'd0) begin
                     buf0_d = cap_word_s;
                  end else begin
                     buf1_d = cap_word_s;
                  end
                  cnt_d = cnt_q + 2'd1;
               end
               default: begin
                  cnt_d = cnt_q;
               end
            endcase

            if (capture_s) begin
               capt_d = capt_q + CW'(1);
               if (capt_q == LAST_IDX) begin
                  err_d = err_q | ~fifo_out_data[DWIDTH];
               end else begin
                  err_d = err_q | fifo_out_data[DWIDTH];
               end
            end else begin
               capt_d = capt_q;
            end

            if (accept_s) begin
               addr_d = addr_q + AWIDTH'(ADDR_STEP);
               pix_d  = pix_q + CW'(1);
               if (pix_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               pix_d = pix_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         addr_q   <= {AWIDTH{1'b0}};
         pix_q    <= {CW{1'b0}};
         popped_q <= {CW{1'b0}};
         capt_q   <= {CW{1'b0}};
         infl_q   <= 1'b0;
         cnt_q    <= 2'd0;
         buf0_q   <= {DWIDTH{1'b0}};
         buf1_q   <= {DWIDTH{1'b0}};
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         pix_q    <= pix_d;
         popped_q <= popped_d;
         capt_q   <= capt_d;
         infl_q   <= rdreq_s;
         cnt_q    <= cnt_d;
         buf0_q   <= buf0_d;
         buf1_q   <= buf1_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

endmodule
